// File: rtl/fust_gen_if.sv
// rtl/fust_gen_if.sv - signal bundle between a dispatcher/FU and the fust_gen status table
// Purpose: groups dispatch, writeback wakeup, issue, completion and status signals.
// Signals:
//   disp_valid/disp_ready, disp_rd/rs1/rs2/imm, disp_t1/t2 : dispatch handshake and op fields
//   wb_valid[NWB], wb_tag[NWB*TAG_W]                        : writeback tag broadcasts
//   issue_valid/issue_ready, issue_row/rd/rs1/rs2/imm       : offered op to the FU
//   done_valid, done_row                                    : FU completion
//   flush                                                   : squash all rows
//   busy[NROWS], free_count                                 : table occupancy
// Modports: master = dispatcher/FU side, slave = status table.
interface fust_gen_if #(
   parameter int NROWS = 4,
   parameter int TAG_W = 2,
   parameter int NWB   = 2,
   parameter int REG_W = 5,
   parameter int IMM_W = 32,
   parameter int ROW_W = $clog2(NROWS),
   parameter int CNT_W = $clog2(NROWS + 1)
);
   logic                   disp_valid;
   logic                   disp_ready;
   logic [REG_W-1:0]       disp_rd;
   logic [REG_W-1:0]       disp_rs1;
   logic [REG_W-1:0]       disp_rs2;
   logic [IMM_W-1:0]       disp_imm;
   logic [TAG_W-1:0]       disp_t1;
   logic [TAG_W-1:0]       disp_t2;
   logic [NWB-1:0]         wb_valid;
   logic [NWB*TAG_W-1:0]   wb_tag;
   logic                   issue_valid;
   logic                   issue_ready;
   logic [ROW_W-1:0]       issue_row;
   logic [REG_W-1:0]       issue_rd;
   logic [REG_W-1:0]       issue_rs1;
   logic [REG_W-1:0]       issue_rs2;
   logic [IMM_W-1:0]       issue_imm;
   logic                   done_valid;
   logic [ROW_W-1:0]       done_row;
   logic                   flush;
   logic [NROWS-1:0]       busy;
   logic [CNT_W-1:0]       free_count;

   modport master (
      output disp_valid, disp_rd, disp_rs1, disp_rs2, disp_imm, disp_t1, disp_t2,
      output wb_valid, wb_tag, issue_ready, done_valid, done_row, flush,
      input  disp_ready, issue_valid, issue_row, issue_rd, issue_rs1, issue_rs2, issue_imm,
      input  busy, free_count
   );

   modport slave (
      input  disp_valid, disp_rd, disp_rs1, disp_rs2, disp_imm, disp_t1, disp_t2,
      input  wb_valid, wb_tag, issue_ready, done_valid, done_row, flush,
      output disp_ready, issue_valid, issue_row, issue_rd, issue_rs1, issue_rs2, issue_imm,
      output busy, free_count
   );
endinterface

// File: rtl/fust_gen.sv
// rtl/fust_gen.sv - parametrised functional unit status table with wakeup and oldest-first issue
// Purpose: holds up to NROWS in-flight ops for one FU, wakes operand tags on writeback
//   broadcasts, offers the oldest ready op to the FU and frees rows on completion.
// Ports:
//   CLK  : clock
//   RST  : synchronous active-high reset
//   bus  : fust_gen_if.slave (dispatch, wakeup, issue, done, flush, busy, free_count)
module fust_gen #(
   parameter int NROWS = 4,
   parameter int TAG_W = 2,
   parameter int NWB   = 2,
   parameter int REG_W = 5,
   parameter int IMM_W = 32,
   parameter int ROW_W = $clog2(NROWS)
) (
   input logic       CLK,
   input logic       RST,
   fust_gen_if.slave bus
);
   localparam int CNT_W = $clog2(NROWS + 1);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_WAIT  = 2'd1,
      S_RDY   = 2'd2,
      S_EX    = 2'd3
   } row_state_e;

   row_state_e       state_q [NROWS];
   row_state_e       state_d [NROWS];
   logic [TAG_W-1:0] t1_q    [NROWS];
   logic [TAG_W-1:0] t1_d    [NROWS];
   logic [TAG_W-1:0] t2_q    [NROWS];
   logic [TAG_W-1:0] t2_d    [NROWS];
   logic [REG_W-1:0] rd_q    [NROWS];
   logic [REG_W-1:0] rs1_q   [NROWS];
   logic [REG_W-1:0] rs2_q   [NROWS];
   logic [IMM_W-1:0] imm_q   [NROWS];

   // older_q[i][j] = row i was dispatched before row j. Every allocation makes the new
   // row younger than all others, so the matrix is always a strict total order with a
   // zero diagonal; no counter exists that could wrap.
   logic [NROWS-1:0] older_q [NROWS];
   logic [NROWS-1:0] older_d [NROWS];

   logic [NROWS-1:0] busy_v;
   logic [NROWS-1:0] rdy;
   logic [CNT_W-1:0] free_cnt;
   logic             has_empty;
   logic [ROW_W-1:0] alloc_row;
   logic             iss_found;
   logic [ROW_W-1:0] iss_row;
   logic             is_oldest;
   logic             disp_fire;
   logic             issue_fire;
   logic             done_fire;
   logic [TAG_W-1:0] disp_t1_eff;
   logic [TAG_W-1:0] disp_t2_eff;

   // Tag 0 means "available", so it never matches a broadcast.
   function automatic logic tag_hit(input logic [TAG_W-1:0]     t,
                                    input logic [NWB-1:0]       v,
                                    input logic [NWB*TAG_W-1:0] tags);
      tag_hit = 1'b0;
      for (int k = 0; k < NWB; k++) begin
         if (v[k] && (t != '0) && (tags[k*TAG_W +: TAG_W] == t)) tag_hit = 1'b1;
      end
   endfunction

   // Occupancy, lowest free row and oldest ready row, all from registered state.
   always_comb begin
      busy_v    = '0;
      rdy       = '0;
      free_cnt  = '0;
      has_empty = 1'b0;
      alloc_row = '0;
      iss_found = 1'b0;
      iss_row   = '0;
      is_oldest = 1'b0;
      for (int i = NROWS - 1; i >= 0; i--) begin
         busy_v[i] = (state_q[i] != S_EMPTY);
         rdy[i]    = (state_q[i] == S_RDY);
         if (state_q[i] == S_EMPTY) begin
            has_empty = 1'b1;
            alloc_row = ROW_W'(i);
            free_cnt  = free_cnt + CNT_W'(1);
         end
      end
      for (int i = 0; i < NROWS; i++) begin
         if (rdy[i]) begin
            is_oldest = 1'b1;
            for (int j = 0; j < NROWS; j++) begin
               if (rdy[j] && older_q[j][i]) is_oldest = 1'b0;
            end
            if (is_oldest) begin
               iss_found = 1'b1;
               iss_row   = ROW_W'(i);
            end
         end
      end
   end

   assign disp_fire  = bus.disp_valid && has_empty && !bus.flush;
   assign issue_fire = iss_found && bus.issue_ready && !bus.flush;
   assign done_fire  = bus.done_valid && !bus.flush &&
                       (int'(bus.done_row) < NROWS) && (state_q[bus.done_row] == S_EX);

   // Next-state: wakeup, issue, done and dispatch always touch distinct rows
   // (WAIT, RDY, EX and EMPTY respectively), so they compose without conflict.
   always_comb begin
      for (int i = 0; i < NROWS; i++) begin
         state_d[i] = state_q[i];
         t1_d[i]    = t1_q[i];
         t2_d[i]    = t2_q[i];
         older_d[i] = older_q[i];
      end
      disp_t1_eff = tag_hit(bus.disp_t1, bus.wb_valid, bus.wb_tag) ? '0 : bus.disp_t1;
      disp_t2_eff = tag_hit(bus.disp_t2, bus.wb_valid, bus.wb_tag) ? '0 : bus.disp_t2;

      for (int i = 0; i < NROWS; i++) begin
         if (state_q[i] != S_EMPTY) begin
            if (tag_hit(t1_q[i], bus.wb_valid, bus.wb_tag)) t1_d[i] = '0;
            if (tag_hit(t2_q[i], bus.wb_valid, bus.wb_tag)) t2_d[i] = '0;
            if ((state_q[i] == S_WAIT) && (t1_d[i] == '0) && (t2_d[i] == '0))
               state_d[i] = S_RDY;
         end
      end

      if (issue_fire) state_d[iss_row] = S_EX;
      if (done_fire) state_d[bus.done_row] = S_EMPTY;

      if (disp_fire) begin
         t1_d[alloc_row]    = disp_t1_eff;
         t2_d[alloc_row]    = disp_t2_eff;
         state_d[alloc_row] = ((disp_t1_eff == '0) && (disp_t2_eff == '0)) ? S_RDY : S_WAIT;
         for (int j = 0; j < NROWS; j++) older_d[j][alloc_row] = 1'b1;
         older_d[alloc_row] = '0;
      end

      if (bus.flush) begin
         for (int i = 0; i < NROWS; i++) begin
            state_d[i] = S_EMPTY;
            t1_d[i]    = '0;
            t2_d[i]    = '0;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < NROWS; i++) begin
            state_q[i] <= S_EMPTY;
            t1_q[i]    <= '0;
            t2_q[i]    <= '0;
            rd_q[i]    <= '0;
            rs1_q[i]   <= '0;
            rs2_q[i]   <= '0;
            imm_q[i]   <= '0;
            for (int j = 0; j < NROWS; j++) older_q[i][j] <= (i < j);
         end
      end else begin
         for (int i = 0; i < NROWS; i++) begin
            state_q[i] <= state_d[i];
            t1_q[i]    <= t1_d[i];
            t2_q[i]    <= t2_d[i];
            older_q[i] <= older_d[i];
         end
         if (disp_fire) begin
            rd_q[alloc_row]  <= bus.disp_rd;
            rs1_q[alloc_row] <= bus.disp_rs1;
            rs2_q[alloc_row] <= bus.disp_rs2;
            imm_q[alloc_row] <= bus.disp_imm;
         end
      end
   end

   assign bus.disp_ready  = has_empty;
   assign bus.free_count  = free_cnt;
   assign bus.busy        = busy_v;
   assign bus.issue_valid = iss_found && !bus.flush;
   assign bus.issue_row   = iss_row;
   assign bus.issue_rd    = iss_found ? rd_q[iss_row]  : '0;
   assign bus.issue_rs1   = iss_found ? rs1_q[iss_row] : '0;
   assign bus.issue_rs2   = iss_found ? rs2_q[iss_row] : '0;
   assign bus.issue_imm   = iss_found ? imm_q[iss_row] : '0;
endmodule

// File: tb/tb_fust_gen.sv
// tb/tb_fust_gen.sv - directed and randomized self-checking bench for fust_gen
module tb_fust_gen;
   localparam int NROWS = 4;
   localparam int TAG_W = 2;
   localparam int NWB   = 2;
   localparam int REG_W = 5;
   localparam int IMM_W = 32;
   localparam int ROW_W = 2;
   localparam int S_E = 0, S_W = 1, S_R = 2, S_X = 3;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   fust_gen_if #(.NROWS(NROWS), .TAG_W(TAG_W), .NWB(NWB), .REG_W(REG_W), .IMM_W(IMM_W)) bus ();

   fust_gen #(.NROWS(NROWS), .TAG_W(TAG_W), .NWB(NWB), .REG_W(REG_W), .IMM_W(IMM_W),
              .ROW_W(ROW_W)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   // Reference model: per-row status plus a dispatch sequence number for age.
   int          m_st  [NROWS];
   int          m_t1  [NROWS];
   int          m_t2  [NROWS];
   int          m_rd  [NROWS];
   int          m_rs1 [NROWS];
   int          m_rs2 [NROWS];
   logic [31:0] m_imm [NROWS];
   longint      m_seq [NROWS];
   longint      next_seq = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void model_clear();
      for (int i = 0; i < NROWS; i++) begin
         m_st[i] = S_E; m_t1[i] = 0; m_t2[i] = 0;
         m_rd[i] = 0; m_rs1[i] = 0; m_rs2[i] = 0; m_imm[i] = 0;
      end
   endfunction

   function automatic int m_free();
      int n = 0;
      for (int i = 0; i < NROWS; i++) if (m_st[i] == S_E) n++;
      return n;
   endfunction

   function automatic logic [NROWS-1:0] m_busy();
      logic [NROWS-1:0] b = '0;
      for (int i = 0; i < NROWS; i++) b[i] = (m_st[i] != S_E);
      return b;
   endfunction

   function automatic int m_oldest();
      int best = -1;
      for (int i = 0; i < NROWS; i++)
         if (m_st[i] == S_R && (best < 0 || m_seq[i] < m_seq[best])) best = i;
      return best;
   endfunction

   function automatic bit m_hit(input int t);
      if (t == 0) return 1'b0;
      for (int k = 0; k < NWB; k++)
         if (bus.wb_valid[k] && int'(bus.wb_tag[k*TAG_W +: TAG_W]) == t) return 1'b1;
      return 1'b0;
   endfunction

   task automatic idle();
      RST = 1'b0;
      bus.disp_valid = 0; bus.disp_rd = 0; bus.disp_rs1 = 0; bus.disp_rs2 = 0;
      bus.disp_imm = 0; bus.disp_t1 = 0; bus.disp_t2 = 0;
      bus.wb_valid = 0; bus.wb_tag = 0; bus.issue_ready = 0;
      bus.done_valid = 0; bus.done_row = 0; bus.flush = 0;
   endtask

   // One clock: compare outputs against the model, advance the model, clock, idle inputs.
   task automatic step();
      int o, ir, dr, ar;
      #1;
      o = m_oldest();
      chk("disp_ready", bus.disp_ready, m_free() > 0);
      chk("free_count", bus.free_count, m_free());
      chk("busy", bus.busy, m_busy());
      chk("issue_valid", bus.issue_valid, (o >= 0) && !bus.flush);
      if (o >= 0) begin
         chk("issue_row", bus.issue_row, o);
         chk("issue_rd", bus.issue_rd, m_rd[o]);
         chk("issue_rs1", bus.issue_rs1, m_rs1[o]);
         chk("issue_rs2", bus.issue_rs2, m_rs2[o]);
         chk("issue_imm", bus.issue_imm, m_imm[o]);
      end
      if (RST || bus.flush) begin
         model_clear();
      end else begin
         ir = (o >= 0 && bus.issue_ready) ? o : -1;
         dr = (bus.done_valid && m_st[bus.done_row] == S_X) ? int'(bus.done_row) : -1;
         ar = -1;
         if (bus.disp_valid)
            for (int i = NROWS - 1; i >= 0; i--) if (m_st[i] == S_E) ar = i;
         for (int i = 0; i < NROWS; i++) begin
            if (m_st[i] != S_E) begin
               if (m_hit(m_t1[i])) m_t1[i] = 0;
               if (m_hit(m_t2[i])) m_t2[i] = 0;
               if (m_st[i] == S_W && m_t1[i] == 0 && m_t2[i] == 0) m_st[i] = S_R;
            end
         end
         if (ir >= 0) m_st[ir] = S_X;
         if (dr >= 0) m_st[dr] = S_E;
         if (ar >= 0) begin
            m_t1[ar]  = m_hit(bus.disp_t1) ? 0 : int'(bus.disp_t1);
            m_t2[ar]  = m_hit(bus.disp_t2) ? 0 : int'(bus.disp_t2);
            m_st[ar]  = (m_t1[ar] == 0 && m_t2[ar] == 0) ? S_R : S_W;
            m_rd[ar]  = bus.disp_rd;
            m_rs1[ar] = bus.disp_rs1;
            m_rs2[ar] = bus.disp_rs2;
            m_imm[ar] = bus.disp_imm;
            m_seq[ar] = next_seq;
            next_seq++;
         end
      end
      @(posedge CLK);
      @(negedge CLK);
      idle();
   endtask

   task automatic disp(input int rd, input int rs1, input int rs2, input int imm,
                       input int t1, input int t2);
      bus.disp_valid = 1;
      bus.disp_rd  = REG_W'(rd);
      bus.disp_rs1 = REG_W'(rs1);
      bus.disp_rs2 = REG_W'(rs2);
      bus.disp_imm = IMM_W'(imm);
      bus.disp_t1  = TAG_W'(t1);
      bus.disp_t2  = TAG_W'(t2);
   endtask

   task automatic do_reset();
      RST = 1'b1;
      step();
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_disp_ready"}, bus.disp_ready, 1);
      chk({tag, "_issue_valid"}, bus.issue_valid, 0);
      chk({tag, "_issue_row"}, bus.issue_row, 0);
      chk({tag, "_issue_rd"}, bus.issue_rd, 0);
      chk({tag, "_issue_imm"}, bus.issue_imm, 0);
      chk({tag, "_busy"}, bus.busy, 0);
      chk({tag, "_free"}, bus.free_count, 4);
   endtask

   task automatic rand_phase(input int cycles);
      int cand[$];
      for (int c = 0; c < cycles; c++) begin
         RST = ($urandom_range(0, 99) == 0);
         if ($urandom_range(0, 1) == 1)
            disp($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
         bus.wb_valid    = NWB'($urandom);
         bus.wb_tag      = (NWB*TAG_W)'($urandom);
         bus.issue_ready = ($urandom_range(0, 2) != 0);
         bus.done_valid  = ($urandom_range(0, 2) == 0);
         cand.delete();
         for (int i = 0; i < NROWS; i++) if (m_st[i] == S_X) cand.push_back(i);
         if (cand.size() > 0 && $urandom_range(0, 3) != 0)
            bus.done_row = ROW_W'(cand[$urandom_range(0, cand.size() - 1)]);
         else
            bus.done_row = ROW_W'($urandom_range(0, NROWS - 1));
         bus.flush = ($urandom_range(0, 39) == 0);
         step();
      end
   endtask

   initial begin
      idle();
      RST = 1'b1;
      repeat (2) @(negedge CLK);
      model_clear();
      RST = 1'b0;
      check_reset_state("reset");

      // Single ready dispatch issues the next cycle.
      disp(3, 1, 2, 'h10, 0, 0);
      step();
      chk("t1_issue_valid", bus.issue_valid, 1);
      chk("t1_issue_row", bus.issue_row, 0);
      chk("t1_issue_imm", bus.issue_imm, 'h10);
      chk("t1_free", bus.free_count, 3);

      // Younger ready op overtakes an older waiting op; wakeup on port 1.
      do_reset();
      disp(4, 5, 6, 'hA, 2, 0);
      step();
      disp(7, 8, 9, 'hB, 0, 0);
      step();
      chk("t2_issue_row_b", bus.issue_row, 1);
      chk("t2_issue_imm_b", bus.issue_imm, 'hB);
      bus.issue_ready = 1;
      step();
      bus.wb_valid = 2'b10;
      bus.wb_tag   = 4'b1000;
      step();
      chk("t2_issue_valid_a", bus.issue_valid, 1);
      chk("t2_issue_row_a", bus.issue_row, 0);
      chk("t2_issue_imm_a", bus.issue_imm, 'hA);

      // Same-cycle bypass of a dispatched tag.
      do_reset();
      disp(1, 1, 1, 'h33, 1, 0);
      bus.wb_valid = 2'b01;
      bus.wb_tag   = 4'b0001;
      step();
      chk("t3_issue_valid", bus.issue_valid, 1);
      chk("t3_issue_row", bus.issue_row, 0);

      // Fill, hold off extra dispatch, then wake all and issue in age order.
      do_reset();
      for (int i = 0; i < NROWS; i++) begin
         disp(i, i, i, 'h100 + i, 3, 0);
         step();
      end
      chk("t4_disp_ready", bus.disp_ready, 0);
      chk("t4_free", bus.free_count, 0);
      disp(9, 9, 9, 'h999, 0, 0);
      step();
      chk("t4_busy_full", bus.busy, 4'hF);
      chk("t4_issue_valid_wait", bus.issue_valid, 0);
      bus.wb_valid = 2'b01;
      bus.wb_tag   = 4'b0011;
      step();
      for (int i = 0; i < NROWS; i++) begin
         chk("t4_order_row", bus.issue_row, i);
         chk("t4_order_imm", bus.issue_imm, 'h100 + i);
         bus.issue_ready = 1;
         step();
      end

      // Done on row 2 with simultaneous dispatch; repeated done ignored.
      do_reset();
      for (int i = 0; i < 3; i++) begin
         disp(i, 0, 0, 'h200 + i, 0, 0);
         step();
      end
      for (int i = 0; i < 3; i++) begin
         bus.issue_ready = 1;
         step();
      end
      chk("t5_busy_ex", bus.busy, 4'b0111);
      bus.done_valid = 1;
      bus.done_row   = 2;
      disp(5, 5, 5, 'h250, 0, 0);
      step();
      chk("t5_busy_after", bus.busy, 4'b1011);
      chk("t5_new_row", bus.issue_row, 3);
      chk("t5_new_imm", bus.issue_imm, 'h250);
      bus.done_valid = 1;
      bus.done_row   = 2;
      step();
      chk("t5_busy_dup", bus.busy, 4'b1011);
      chk("t5_free_dup", bus.free_count, 1);

      // Flush with WAIT/RDY/EX rows present, then the same with reset.
      for (int pass = 0; pass < 2; pass++) begin
         do_reset();
         disp(1, 1, 1, 'h300, 3, 0);
         step();
         disp(2, 2, 2, 'h301, 0, 0);
         step();
         disp(3, 3, 3, 'h302, 0, 0);
         bus.issue_ready = 1;
         step();
         chk("t6_busy_pre", bus.busy, 4'b0111);
         disp(4, 4, 4, 'h303, 0, 0);
         bus.issue_ready = 1;
         if (pass == 0) begin
            bus.flush = 1;
            #1;
            chk("t6_flush_issue_valid", bus.issue_valid, 0);
         end else begin
            RST = 1'b1;
         end
         step();
         chk("t6_busy_post", bus.busy, 0);
         chk("t6_free_post", bus.free_count, 4);
         chk("t6_issue_valid_post", bus.issue_valid, 0);
      end

      do_reset();
      rand_phase(600);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/fust_gen.md
Name: fust_gen

Overview:
- Parametrised successor to the fixed 3-row scalar functional unit status table.
- Holds up to NROWS in-flight ops for one functional unit, each with two operand producer tags.
- Wakes operands on NWB writeback tag broadcasts and issues the oldest ready op to the FU.
- Tracks each row through EMPTY/WAIT/RDY/EX and frees it on FU completion.

Parameters:
- NROWS, 4, number of status rows (>=2)
- TAG_W, 2, producer tag width; tag value 0 = operand available
- NWB, 2, number of writeback broadcast ports
- REG_W, 5, register index width
- IMM_W, 32, immediate width
- ROW_W, $clog2(NROWS), row index width (derived)

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- disp_valid  in  1  dispatch request
- disp_ready  out  1  at least one EMPTY row
- disp_rd / disp_rs1 / disp_rs2  in  REG_W each  register fields
- disp_imm  in  IMM_W  immediate
- disp_t1 / disp_t2  in  TAG_W each  producer tags for rs1/rs2
- wb_valid  in  NWB  per-port writeback strobe
- wb_tag  in  NWB*TAG_W  per-port completing tag (port k at bits [k*TAG_W +: TAG_W])
- issue_valid  out  1  a RDY row is offered
- issue_ready  in  1  FU accepts
- issue_row  out  ROW_W  offered row index
- issue_rd / issue_rs1 / issue_rs2  out  REG_W each  offered fields
- issue_imm  out  IMM_W  offered immediate
- done_valid  in  1  FU finished an op
- done_row  in  ROW_W  row being retired
- flush  in  1  squash all rows
- busy  out  NROWS  per-row non-EMPTY flag
- free_count  out  $clog2(NROWS+1)  number of EMPTY rows

Behaviour:
- Per-row state is one of EMPTY, WAIT, RDY, EX, plus stored fields, t1, t2 and relative age.
- Reset (RST=1 at posedge): all rows EMPTY, tags 0, busy=0, free_count=NROWS.
  - Consequently disp_ready=1, issue_valid=0, and issue_row/issue_* = 0.
  - Applies mid-operation; no in-flight state survives.
- Dispatch:
  - Transfer occurs when disp_valid && disp_ready && !flush.
  - Allocates the lowest-index EMPTY row at the posedge.
  - Captured tags are bypassed: any disp_tN equal to a valid wb_tag in the same cycle is stored as 0.
  - Next state is RDY if both stored tags are 0, otherwise WAIT.
  - disp_ready is combinational from registered state only (it does not depend on same-cycle done).
- Wakeup:
  - For every non-EMPTY row, t1/t2 are cleared at the posedge if equal to any wb_tag[k] with wb_valid[k]=1.
  - A nonzero tag never matches tag 0.
  - WAIT -> RDY at the posedge where both tags become (or already are) 0.
- Issue:
  - issue_valid = any RDY row && !flush.
  - issue_row is the oldest RDY row, i.e. earliest accepted dispatch.
  - issue_* outputs come from that row, combinationally from registered state.
  - When issue_valid && issue_ready, that row goes RDY -> EX at the posedge.
  - Minimum dispatch-to-issue latency is 1 cycle (dispatch at N, issue_valid at N+1).
  - Wakeup-to-issue latency is 1 cycle.
- Completion: done_valid with done_row in EX makes that row EMPTY at the posedge. done_valid on a non-EX or out-of-range row is ignored; the table is unchanged.
- Simultaneous events:
  - Dispatch, issue, done and wakeup in one cycle all apply, each on distinct rows.
  - A row freed by done is not reallocated in the same cycle.
- Age:
  - The oldest row is the earliest-dispatched live row.
  - Freeing a row does not reorder the others.
  - Age ordering must stay correct with no wraparound errors across unbounded dispatch counts.
- Full: free_count=0 drives disp_ready=0; disp_valid is held off without any state change.
- Flush:
  - Next state is all rows EMPTY, including EX rows.
  - Flush takes priority over dispatch, issue and done.
  - The FU is responsible for discarding the flushed EX op.
- busy[i] = (state[i] != EMPTY); free_count = NROWS minus popcount(busy).

Test Plan:
- Reset, then dispatch rd=3, rs1=1, rs2=2, imm=0x10, t1=t2=0 -> next cycle row0 RDY, issue_valid=1, issue_row=0, issue_imm=0x10, free_count=3.
- Dispatch A with t1=2 (row0), then B with t1=t2=0 (row1) -> B issues first. Then wb_valid[1]=1, wb_tag=2 -> A goes RDY next cycle and issues.
- Dispatch with t1=1 while wb_valid[0]=1, wb_tag[0]=1 in the same cycle -> row enters RDY directly, issue_valid=1 the next cycle.
- Fill 4 rows with t1=3 -> disp_ready=0 and free_count=0. Extra disp_valid is ignored. Then wb tag 3 -> rows issue in dispatch order 0,1,2,3 with issue_ready held 1.
- Row2 in EX, done_valid with done_row=2 plus simultaneous dispatch -> new op allocates a different EMPTY row. Row2 is EMPTY next cycle and busy[2]=0. A second done on row2 is ignored.
- Rows in WAIT/RDY/EX, assert flush together with disp_valid and issue_ready -> issue_valid=0 that cycle, next cycle busy=0 and free_count=4, and the dispatch is not captured. Repeat with RST mid-operation -> identical result.
